// File: rtl/rom_arb_pkg.sv
// Shared constants and FSM state type for the ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned ID_W     = 3;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rom_arb_picker.sv
// Combinational winner selection: first asserted request at or after ptr, wrapping.
module rom_arb_picker
  import rom_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] winner,
  output logic [ID_W-1:0] winner_id,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum;

  // Rotate so the requester at ptr sits at bit 0.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = ID_W'(i);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W + 1)'(NREQ)) begin
      sum = sum - (ID_W + 1)'(NREQ);
    end
    winner_id = sum[ID_W-1:0];
    winner    = any ? (NREQ'(1) << winner_id) : '0;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates NREQ read requesters onto one registered-read ROM port.
// Define ROM_ARB_RR_EN for round-robin; fixed priority (lowest index) otherwise.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 256,
  parameter int unsigned NREQ   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] addr,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [WIDTH-1:0]           rdata,
  output logic                       err,
  output logic                       rom_en,
  output logic [WIDTH-1:0]           rom_addr,
  input  logic [WIDTH-1:0]           rom_rd
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q;
  logic [ID_W-1:0] pend_id_q;
  logic            err_q;
  logic [WIDTH-1:0] rdata_q;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] win;
  logic [ID_W-1:0] win_id;
  logic            win_any;
  logic [ID_W-1:0] ptr;
  logic            oor;

  // A requester still sees req high in its grant cycle; keep it out of the race.
  assign eligible = req & ~gnt_q;

`ifdef ROM_ARB_RR_EN
  logic [ID_W-1:0] ptr_q;
  logic [ID_W:0]   ptr_nxt;

  assign ptr     = ptr_q;
  assign ptr_nxt = {1'b0, win_id} + (ID_W + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (win_any) begin
      ptr_q <= (ptr_nxt == (ID_W + 1)'(NREQ)) ? '0 : ptr_nxt[ID_W-1:0];
    end
  end
`else
  assign ptr = '0;
`endif

  rom_arb_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req       (eligible),
    .ptr       (ptr),
    .winner    (win),
    .winner_id (win_id),
    .any       (win_any)
  );

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rom_addr = rom_addr | (addr[i] & {WIDTH{win[i]}});
    end
  end

  assign rom_en  = win_any;
  assign oor     = rom_addr[WIDTH-1:2] >= (WIDTH - 2)'(LENGTH);
  assign state_d = win_any ? ARB_ACTIVE : ARB_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      pend_id_q <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= win;
      err_q   <= win_any & oor;
      if (win_any) begin
        pend_id_q <= win_id;
      end
      if (state_q == ARB_ACTIVE) begin
        rdata_q <= rdata;
      end
    end
  end

  // ACTIVE means exactly one response is landing this cycle.
  assign gnt    = gnt_q;
  assign err    = err_q;
  assign rvalid = (state_q == ARB_ACTIVE) ? (NREQ'(1) << pend_id_q) : '0;
  assign rdata  = (state_q == ARB_ACTIVE) ? (err_q ? '0 : rom_rd) : rdata_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed vector bench for rom_read_arbiter with a registered ROM model.
module tb_rom_read_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][31:0] addr;
  logic [3:0]       gnt;
  logic [3:0]       rvalid;
  logic [31:0]      rdata;
  logic             err;
  logic             rom_en;
  logic [31:0]      rom_addr;
  logic [31:0]      rom_rd;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mem [256];

  rom_read_arbiter #(
    .WIDTH  (32),
    .LENGTH (256),
    .NREQ   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return all ones so a missing zeroing in the DUT shows.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_rd <= (rom_addr[31:2] < 30'd256) ? mem[rom_addr[9:2]] : 32'hFFFF_FFFF;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] addr;
    logic        en;
    logic [31:0] raddr;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [3:0] exp_g;
    int         idx;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
    mem[4] = 32'hDEAD_BEEF;

    // Registered fields are what the outputs show during the row's cycle.
    vecs[0] = '{4'b0000, 32'h000, 1'b0, 32'h000, 4'b0000, 4'b0000, 32'h0,          1'b0};
    vecs[1] = '{4'b0010, 32'h010, 1'b1, 32'h010, 4'b0000, 4'b0000, 32'h0,          1'b0};
    vecs[2] = '{4'b0000, 32'h000, 1'b0, 32'h000, 4'b0010, 4'b0010, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{4'b0000, 32'h000, 1'b0, 32'h000, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{4'b1000, 32'h020, 1'b1, 32'h020, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{4'b0001, 32'h400, 1'b1, 32'h400, 4'b1000, 4'b1000, 32'hA500_0008, 1'b0};
    vecs[6] = '{4'b0100, 32'h3FC, 1'b1, 32'h3FC, 4'b0001, 4'b0001, 32'h0,          1'b1};
    vecs[7] = '{4'b0000, 32'h000, 1'b0, 32'h000, 4'b0100, 4'b0100, 32'hA500_00FF, 1'b0};
    vecs[8] = '{4'b0000, 32'h000, 1'b0, 32'h000, 4'b0000, 4'b0000, 32'hA500_00FF, 1'b0};

    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req  = vecs[k].req;
      addr = {4{vecs[k].addr}};
      #1;
      chk($sformatf("v%0d_rom_en", k), 32'(rom_en), 32'(vecs[k].en));
      chk($sformatf("v%0d_rom_addr", k), rom_addr, vecs[k].raddr);
      chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(vecs[k].gnt));
      chk($sformatf("v%0d_rvalid", k), 32'(rvalid), 32'(vecs[k].rvalid));
      chk($sformatf("v%0d_rdata", k), rdata, vecs[k].rdata);
      chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].err));
    end

    // Reset in the cycle after a grant: the response must be dropped.
    @(negedge clk);
    req  = 4'b0010;
    addr = {4{32'h010}};
    @(posedge clk);
    #1;
    chk("mid_gnt_before_rst", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt_early", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    chk("post_rst_err", 32'(err), 32'h0);

    // All four requesters held; pointer must start at 0 after reset.
    @(negedge clk);
    req  = 4'b1111;
    addr = {32'h00C, 32'h008, 32'h004, 32'h000};
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
`ifdef ROM_ARB_RR_EN
      idx = k % 4;
`else
      idx = k % 2;
`endif
      exp_g = 4'b0001 << idx;
      chk($sformatf("all_gnt_%0d", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("all_rvalid_%0d", k), 32'(rvalid), 32'(exp_g));
      chk($sformatf("all_rdata_%0d", k), rdata, 32'hA500_0000 + idx);
    end

    @(negedge clk);
    req = 4'b1000;
`ifdef ROM_ARB_RR_EN
    @(posedge clk);
    #1;
    chk("drop_gnt_excluded", 32'(gnt), 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("drop_gnt3", 32'(gnt), 32'h8);
    chk("drop_rdata3", rdata, 32'hA500_0003);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("final_idle_gnt", 32'(gnt), 32'h0);
    chk("final_idle_rvalid", 32'(rvalid), 32'h0);
    chk("final_rdata_hold", rdata, 32'hA500_0003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and byte-address width.
REQ-002 SHALL have parameter LENGTH, default 256, ROM depth in words.
REQ-003 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port req, input, NREQ, per-requester read request; held until granted.
REQ-007 SHALL have port addr, input, NREQ x WIDTH, per-requester byte address; stable while req high.
REQ-008 SHALL have port gnt, output, NREQ, one-hot grant, registered.
REQ-009 SHALL have port rvalid, output, NREQ, one-hot response-valid, registered.
REQ-010 SHALL have port rdata, output, WIDTH, read data, shared by all requesters.
REQ-011 SHALL have port err, output, 1, out-of-range flag, aligned with rvalid.
REQ-012 SHALL have port rom_en, output, 1, ROM port read enable.
REQ-013 SHALL have port rom_addr, output, WIDTH, byte address to ROM port; ROM uses bits [WIDTH-1:2].
REQ-014 SHALL have port rom_rd, input, WIDTH, ROM registered read data (1-cycle latency after rom_en).

Function
REQ-015 SHALL arbitrate in cycle N among asserted req bits; rom_en=1 and rom_addr=addr[winner] combinationally in cycle N.
REQ-016 SHALL assert gnt[winner] in cycle N+1 and rvalid[winner] in cycle N+1, with rdata=rom_rd and err valid in N+1.
REQ-017 SHALL exclude from arbitration in cycle N any requester whose gnt is high in cycle N.
REQ-018 SHALL sustain one grant per cycle when requesters differ (back-to-back, no bubble).
REQ-019 SHALL, with no req asserted, drive rom_en=0, rom_addr=0, gnt=0, rvalid=0 next cycle.
REQ-020 SHALL hold rdata at its last value when no rvalid bit is high.
REQ-021 SHALL set err=1 with rvalid when addr[WIDTH-1:2] >= LENGTH; rdata is then 0 and ROM is still enabled.
REQ-022 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on any winner; ACTIVE->IDLE when no winner in a cycle; ACTIVE->ACTIVE otherwise.
REQ-023 SHALL keep at most one response in flight; pending-id register is 3 bits wide.

Reset
REQ-024 SHALL, on rst_n=0, immediately clear gnt, rvalid, err, rdata, pending id, priority pointer (=0), FSM=IDLE.
REQ-025 SHALL, on reset mid-read, drop the in-flight response; no rvalid after rst_n release.
REQ-026 SHALL issue first grant no earlier than the first posedge after rst_n rises.

Configuration
REQ-027 SHALL, with ROM_ARB_RR_EN defined, use round-robin: pointer advances to winner+1 mod NREQ after each grant; search starts at pointer.
REQ-028 SHALL, without ROM_ARB_RR_EN, use fixed priority (lowest index wins); pointer register absent.

Structure
REQ-029 SHALL place ARB_IDLE/ARB_ACTIVE state enum and MAX_NREQ=8 constant in shared package rom_arb_pkg.
REQ-030 SHALL implement winner selection in sub-module rom_arb_picker (combinational, req + pointer -> one-hot winner).

Verification
REQ-031 SHALL verify single req[1], addr=0x10, ROM word4=0xDEADBEEF -> cycle N+1 gnt=0010, rvalid=0010, rdata=0xDEADBEEF, err=0.
REQ-032 SHALL verify req=1111 held 8 cycles with RR -> grant order 0,1,2,3,0,1,2,3, one per cycle after first.
REQ-033 SHALL verify req=1111 without ROM_ARB_RR_EN -> req0 granted; req3 granted only after req0..2 drop.
REQ-034 SHALL verify addr=0x400 (word 256, LENGTH=256) -> rvalid with err=1, rdata=0.
REQ-035 SHALL verify rst_n low in cycle after grant -> rvalid stays 0, pointer=0, FSM=IDLE.
